vend_controller: RTL and testbench
==================================

// Module: vend_controller
// PURPOSE
//  Transaction sequencer for the vending machine. Accepts coins/notes, latches a
//  product selection, checks credit against price, pulses a dispense command and
//  returns change one coin per cycle. Sits between the money-input path and the
//  product selector; owns the single credit register for a transaction.
// PARAMETERS
//  CREDIT_W    16     width of credit/price arithmetic (unsigned)
//  PRICE_STEP  500    price(addr) = (addr+1)*PRICE_STEP; addr 0..7 -> 500..4000
//  MAX_CREDIT  10000  credit ceiling; an insertion that would exceed it is refunded
// PORTS
//  clock          in   1        rising-edge clock
//  reset          in   1        asynchronous, active-high; clears all state
//  money_type     in   4        one-hot per cycle: 0001=500 0010=1000 0100=2000 1000=5000; 0000=none
//  sel_valid      in   1        one-cycle product request strobe
//  address        in   3        product index, sampled when sel_valid=1
//  cancel         in   1        one-cycle abort strobe; refund entire credit
//  credit         out  CREDIT_W current credit
//  busy           out  1        1 in CHECK, DISPENSE, CHANGE
//  dispense_valid out  1        one-cycle pulse: release product dispense_addr
//  dispense_addr  out  3        latched address, valid with dispense_valid
//  change_coin    out  4        one-hot coin returned this cycle (money_type encoding), else 0
//  refund_coin    out  4        echo of a rejected insertion, one cycle after it
//  insufficient   out  1        one-cycle pulse: selection refused, credit < price
//  error          out  1        one-cycle pulse: money_type nonzero and not one-hot
// BEHAVIOUR
//  Reset: state=IDLE; credit=0; dispense_addr=0; all pulse outputs 0; busy=0.
//  All outputs registered. States: IDLE, COLLECT, CHECK, DISPENSE, CHANGE.
//  Insertion (IDLE/COLLECT only): valid one-hot -> credit += value next edge,
//   IDLE->COLLECT. If credit+value > MAX_CREDIT: credit unchanged, refund_coin=money_type.
//   Insertion in CHECK/DISPENSE/CHANGE: never accepted, refund_coin=money_type.
//   Non-one-hot nonzero money_type in any state: error=1, credit unchanged, no refund.
//  Selection: sel_valid in COLLECT -> latch address, go CHECK. sel_valid in IDLE ->
//   insufficient=1, stay IDLE. sel_valid while busy ignored.
//  Same-cycle insertion+sel_valid in COLLECT: both taken; CHECK uses updated credit.
//  Same-cycle cancel+sel_valid: cancel wins, selection dropped.
//  CHECK (1 cycle): credit >= price -> DISPENSE; else insufficient=1, back to COLLECT.
//  DISPENSE (1 cycle): dispense_valid=1, credit -= price; next = CHANGE if remainder>0 else IDLE.
//  Latency: sel_valid edge N -> CHECK at N+1 -> dispense_valid high during N+2.
//  cancel in COLLECT -> CHANGE; cancel in IDLE or busy states ignored.
//  CHANGE: greedy, one coin per cycle, largest of 2000/1000/500 <= credit;
//   change_coin=that coin, credit -= value; 5000 notes never returned as change.
//   credit==0 -> IDLE. Credit is always a multiple of 500, so CHANGE terminates.
//  Arithmetic: unsigned CREDIT_W; compare uses CREDIT_W+1 bits so overflow is impossible.
//  Reset mid-transaction: immediate return to IDLE, credit lost, no pending pulses.
// STRUCTURE
//  Shared package vend_pkg: money_type one-hot codes, coin values (500/1000/2000/5000),
//   state enum, PRICE_STEP and MAX_CREDIT defaults.
//  Sub-module price_lut (combinational): address -> price, used by CHECK.
//  Controller holds FSM, credit register, address latch and pulse registers.
// TESTING
//  1. Insert 1000, 2000; select addr 3 (2000) -> dispense_valid@addr3, change_coin 1000 once, credit 0, IDLE.
//  2. Insert 500; select addr 2 (1500) -> insufficient pulse, state COLLECT, credit 500; cancel -> change_coin 500.
//  3. Insert 5000; select addr 0 (500) -> dispense, change sequence 2000,2000,500; credit 0 after 3 cycles.
//  4. Credit 8000, insert 5000 -> refund_coin=1000(5000 code), credit stays 8000; money_type=0011 -> error, credit 8000.
//  5. Insert 1000 during CHANGE -> refund_coin=0010 next cycle, change sequence unaffected.
//  6. Assert reset during CHANGE with credit 3000 -> credit 0, IDLE, change_coin 0 immediately.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared definitions for the vending transaction sequencer: money codes, coin values,
// controller states and default pricing parameters.
package vend_pkg;

  localparam int unsigned DefPriceStep = 500;
  localparam int unsigned DefMaxCredit = 10000;

  localparam logic [3:0] MoneyNone = 4'b0000;
  localparam logic [3:0] Money500  = 4'b0001;
  localparam logic [3:0] Money1000 = 4'b0010;
  localparam logic [3:0] Money2000 = 4'b0100;
  localparam logic [3:0] Money5000 = 4'b1000;

  localparam int unsigned Val500  = 500;
  localparam int unsigned Val1000 = 1000;
  localparam int unsigned Val2000 = 2000;
  localparam int unsigned Val5000 = 5000;

  typedef enum logic [2:0] {
    StIdle,
    StCollect,
    StCheck,
    StDispense,
    StChange
  } vend_state_e;

  function automatic logic is_one_hot(input logic [3:0] m);
    return (m != MoneyNone) && ((m & (m - 4'd1)) == 4'd0);
  endfunction

  function automatic int unsigned coin_value(input logic [3:0] m);
    int unsigned v;
    v = 0;
    case (m)
      Money500:  v = Val500;
      Money1000: v = Val1000;
      Money2000: v = Val2000;
      Money5000: v = Val5000;
      default:   v = 0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/vend_controller_price_lut.sv
// Product price lookup: price grows linearly with the product index.
module price_lut
  import vend_pkg::*;
#(
  parameter int unsigned CREDIT_W   = 16,
  parameter int unsigned PRICE_STEP = DefPriceStep
) (
  input  logic [2:0]          address,
  output logic [CREDIT_W-1:0] price
);

  logic [31:0] price_full;

  always_comb begin
    price_full = (32'(address) + 32'd1) * PRICE_STEP;
    price      = price_full[CREDIT_W-1:0];
  end

endmodule

// File: rtl/vend_controller.sv
// Vending transaction sequencer: credit accumulation, selection check, dispense pulse
// and greedy one-coin-per-cycle change return. All outputs are registered.
module vend_controller
  import vend_pkg::*;
#(
  parameter int unsigned CREDIT_W   = 16,
  parameter int unsigned PRICE_STEP = DefPriceStep,
  parameter int unsigned MAX_CREDIT = DefMaxCredit
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [3:0]          money_type,
  input  logic                sel_valid,
  input  logic [2:0]          address,
  input  logic                cancel,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                dispense_valid,
  output logic [2:0]          dispense_addr,
  output logic [3:0]          change_coin,
  output logic [3:0]          refund_coin,
  output logic                insufficient,
  output logic                error
);

  localparam int unsigned WExt = CREDIT_W + 1;
  localparam logic [CREDIT_W:0] MaxExt = WExt'(MAX_CREDIT);
  localparam logic [CREDIT_W:0] C500   = WExt'(Val500);
  localparam logic [CREDIT_W:0] C1000  = WExt'(Val1000);
  localparam logic [CREDIT_W:0] C2000  = WExt'(Val2000);

  vend_state_e state;

  logic [CREDIT_W-1:0] price;
  logic [CREDIT_W:0]   credit_ext, coin_ext, sum_ext, price_ext;
  logic                money_onehot, money_bad, can_insert, over_max, insert_ok, refund_now;
  logic [3:0]          chg_code;
  logic [CREDIT_W:0]   chg_val;

  // Price always follows the latched selection, which is what CHECK evaluates.
  price_lut #(
    .CREDIT_W  (CREDIT_W),
    .PRICE_STEP(PRICE_STEP)
  ) u_price_lut (
    .address(dispense_addr),
    .price  (price)
  );

  always_comb begin
    credit_ext   = {1'b0, credit};
    price_ext    = {1'b0, price};
    money_onehot = is_one_hot(money_type);
    money_bad    = (money_type != MoneyNone) && !money_onehot;
    coin_ext     = WExt'(coin_value(money_type));
    sum_ext      = credit_ext + coin_ext;
    over_max     = sum_ext > MaxExt;
    can_insert   = (state == StIdle) || (state == StCollect);
    insert_ok    = can_insert && money_onehot && !over_max;
    refund_now   = money_onehot && !insert_ok;
  end

  // Greedy change coin; 5000 notes are never paid out.
  always_comb begin
    chg_code = Money500;
    chg_val  = C500;
    if (credit_ext >= C2000) begin
      chg_code = Money2000;
      chg_val  = C2000;
    end else if (credit_ext >= C1000) begin
      chg_code = Money1000;
      chg_val  = C1000;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= StIdle;
      credit         <= '0;
      busy           <= 1'b0;
      dispense_valid <= 1'b0;
      dispense_addr  <= 3'd0;
      change_coin    <= MoneyNone;
      refund_coin    <= MoneyNone;
      insufficient   <= 1'b0;
      error          <= 1'b0;
    end else begin
      dispense_valid <= 1'b0;
      change_coin    <= MoneyNone;
      insufficient   <= 1'b0;
      error          <= money_bad;
      refund_coin    <= refund_now ? money_type : MoneyNone;

      unique case (state)
        StIdle: begin
          if (insert_ok) begin
            credit <= sum_ext[CREDIT_W-1:0];
            state  <= StCollect;
          end
          if (sel_valid) insufficient <= 1'b1;
        end

        StCollect: begin
          if (insert_ok) credit <= sum_ext[CREDIT_W-1:0];
          if (cancel) begin
            state <= StChange;
            busy  <= 1'b1;
          end else if (sel_valid) begin
            dispense_addr <= address;
            state         <= StCheck;
            busy          <= 1'b1;
          end
        end

        StCheck: begin
          if (credit_ext >= price_ext) begin
            credit         <= credit - price;
            dispense_valid <= 1'b1;
            state          <= StDispense;
          end else begin
            insufficient <= 1'b1;
            state        <= StCollect;
            busy         <= 1'b0;
          end
        end

        StDispense: begin
          if (credit != '0) begin
            state <= StChange;
          end else begin
            state <= StIdle;
            busy  <= 1'b0;
          end
        end

        StChange: begin
          // Sub-500 residue cannot occur while credit stays a multiple of 500.
          if (credit_ext < C500) begin
            credit <= '0;
            state  <= StIdle;
            busy   <= 1'b0;
          end else begin
            change_coin <= chg_code;
            credit      <= credit - chg_val[CREDIT_W-1:0];
            if (credit_ext == chg_val) begin
              state <= StIdle;
              busy  <= 1'b0;
            end
          end
        end

        default: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_controller.sv
// Self-checking bench: directed transactions then random stimulus, compared each cycle
// against a transaction-level model of the vending sequencer.
module tb_vend_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  money_type = 4'd0;
  logic        sel_valid = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        cancel = 1'b0;
  logic [15:0] credit;
  logic        busy, dispense_valid, insufficient, error;
  logic [2:0]  dispense_addr;
  logic [3:0]  change_coin, refund_coin;

  vend_controller dut (
    .clock         (clock),
    .reset         (reset),
    .money_type    (money_type),
    .sel_valid     (sel_valid),
    .address       (address),
    .cancel        (cancel),
    .credit        (credit),
    .busy          (busy),
    .dispense_valid(dispense_valid),
    .dispense_addr (dispense_addr),
    .change_coin   (change_coin),
    .refund_coin   (refund_coin),
    .insufficient  (insufficient),
    .error         (error)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_fail = 0;

  // Model: phase name, credit in plain integers, and a queue of change coins still owed.
  typedef enum int {MIdle, MCollect, MCheck, MDispense, MChange} m_phase_e;
  m_phase_e m_phase;
  int       m_credit, m_addr;
  int       owed_q[$];
  int       e_dv, e_chg, e_ref, e_ins, e_err;

  function automatic int code_of(input int v);
    case (v)
      500:     return 1;
      1000:    return 2;
      2000:    return 4;
      5000:    return 8;
      default: return 0;
    endcase
  endfunction

  task automatic plan_change();
    int rem;
    owed_q.delete();
    rem = m_credit;
    while (rem >= 2000) begin owed_q.push_back(2000); rem -= 2000; end
    while (rem >= 1000) begin owed_q.push_back(1000); rem -= 1000; end
    while (rem >= 500)  begin owed_q.push_back(500);  rem -= 500;  end
  endtask

  task automatic model_reset();
    m_phase = MIdle; m_credit = 0; m_addr = 0; owed_q.delete();
    e_dv = 0; e_chg = 0; e_ref = 0; e_ins = 0; e_err = 0;
  endtask

  task automatic model_step(input int mt, input bit sv, input int ad, input bit cn);
    int val, coin, price;
    bit one;
    e_dv = 0; e_chg = 0; e_ref = 0; e_ins = 0;
    one   = ($countones(mt) == 1);
    e_err = (mt != 0) && !one;
    val   = (mt == 1) ? 500 : (mt == 2) ? 1000 : (mt == 4) ? 2000 : (mt == 8) ? 5000 : 0;
    if (one && !(m_phase == MIdle || m_phase == MCollect)) e_ref = mt;
    case (m_phase)
      MIdle, MCollect: begin
        if (one) begin
          if (m_credit + val > 10000) e_ref = mt;
          else m_credit += val;
        end
        if (m_phase == MIdle) begin
          if (sv) e_ins = 1;
          if (m_credit > 0) m_phase = MCollect;
        end else if (cn) begin
          plan_change();
          m_phase = MChange;
        end else if (sv) begin
          m_addr  = ad;
          m_phase = MCheck;
        end
      end
      MCheck: begin
        price = (m_addr + 1) * 500;
        if (m_credit >= price) begin
          m_credit -= price; e_dv = 1; m_phase = MDispense;
        end else begin
          e_ins = 1; m_phase = MCollect;
        end
      end
      MDispense: begin
        if (m_credit > 0) begin plan_change(); m_phase = MChange; end
        else m_phase = MIdle;
      end
      MChange: begin
        coin = owed_q.pop_front();
        e_chg = code_of(coin);
        m_credit -= coin;
        if (owed_q.size() == 0) m_phase = MIdle;
      end
      default: m_phase = MIdle;
    endcase
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    int e_busy;
    e_busy = (m_phase == MCheck || m_phase == MDispense || m_phase == MChange) ? 1 : 0;
    chk({tag, ".credit"}, int'(credit), m_credit);
    chk({tag, ".busy"}, int'(busy), e_busy);
    chk({tag, ".dispense_valid"}, int'(dispense_valid), e_dv);
    chk({tag, ".dispense_addr"}, int'(dispense_addr), m_addr);
    chk({tag, ".change_coin"}, int'(change_coin), e_chg);
    chk({tag, ".refund_coin"}, int'(refund_coin), e_ref);
    chk({tag, ".insufficient"}, int'(insufficient), e_ins);
    chk({tag, ".error"}, int'(error), e_err);
  endtask

  task automatic cycle(input string tag, input logic [3:0] mt, input logic sv,
                       input logic [2:0] ad, input logic cn);
    money_type = mt; sel_valid = sv; address = ad; cancel = cn;
    model_step(int'(mt), sv, int'(ad), cn);
    @(posedge clock);
    #1;
    check_all(tag);
    money_type = 4'd0; sel_valid = 1'b0; cancel = 1'b0;
  endtask

  task automatic idle_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag, 4'd0, 1'b0, 3'd0, 1'b0);
  endtask

  initial begin
    int r, mt;
    model_reset();
    #12;
    check_all("reset");
    reset = 1'b0;
    @(posedge clock); #1;

    // 1: 1000 + 2000, buy addr 3 (2000), one 1000 coin back.
    cycle("t1", 4'b0010, 1'b0, 3'd0, 1'b0);
    cycle("t1", 4'b0100, 1'b0, 3'd0, 1'b0);
    cycle("t1", 4'b0000, 1'b1, 3'd3, 1'b0);
    idle_cycles("t1", 4);
    chk("t1.final_credit", int'(credit), 0);

    // 2: 500 then addr 2 (1500) refused, then cancel returns 500.
    cycle("t2", 4'b0001, 1'b0, 3'd0, 1'b0);
    cycle("t2", 4'b0000, 1'b1, 3'd2, 1'b0);
    idle_cycles("t2", 2);
    cycle("t2", 4'b0000, 1'b0, 3'd0, 1'b1);
    idle_cycles("t2", 2);

    // 3: 5000, addr 0 (500): change 2000, 2000, 500.
    cycle("t3", 4'b1000, 1'b0, 3'd0, 1'b0);
    cycle("t3", 4'b0000, 1'b1, 3'd0, 1'b0);
    idle_cycles("t3", 6);

    // 4: reach 8000, overflowing 5000 refunded, malformed code flagged.
    cycle("t4", 4'b1000, 1'b0, 3'd0, 1'b0);
    cycle("t4", 4'b0100, 1'b0, 3'd0, 1'b0);
    cycle("t4", 4'b0010, 1'b0, 3'd0, 1'b0);
    cycle("t4", 4'b1000, 1'b0, 3'd0, 1'b0);
    chk("t4.refund5000", int'(refund_coin), 8);
    cycle("t4", 4'b0011, 1'b0, 3'd0, 1'b0);
    chk("t4.credit8000", int'(credit), 8000);
    cycle("t4", 4'b0100, 1'b0, 3'd0, 1'b0);
    cycle("t4", 4'b0000, 1'b0, 3'd0, 1'b1);
    idle_cycles("t4", 7);

    // 5: insertion during CHANGE is refunded, change sequence continues.
    cycle("t5", 4'b1000, 1'b0, 3'd0, 1'b0);
    cycle("t5", 4'b0000, 1'b1, 3'd0, 1'b0);
    idle_cycles("t5", 3);
    cycle("t5", 4'b0010, 1'b0, 3'd0, 1'b0);
    idle_cycles("t5", 3);

    // 6: reset in CHANGE with 3000 outstanding.
    cycle("t6", 4'b1000, 1'b0, 3'd0, 1'b0);
    cycle("t6", 4'b0000, 1'b1, 3'd3, 1'b0);
    idle_cycles("t6", 2);
    chk("t6.credit_before", int'(credit), 3000);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all("t6.async");
    @(posedge clock); #1 reset = 1'b0;
    idle_cycles("t6", 1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 65)      mt = 0;
      else if (r < 94) mt = 1 << $urandom_range(0, 3);
      else             mt = int'($urandom_range(1, 15));
      cycle("rand", 4'(mt), ($urandom_range(0, 99) < 15), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 99) < 5));
    end
    idle_cycles("drain", 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
